data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 128, giving the number of 32-bit words of storage.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted per access; the legal range is 0..15.
REQ-003 clk_i  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  is an asynchronous, active-low reset.
REQ-005 req_i  input  1  is the access request from the CPU.
REQ-006 we_i  input  1  selects the access type: 1 = store word, 0 = load word.
REQ-007 addr_i  input  32  is the byte address.
REQ-008 wdata_i  input  32  is the store data.
REQ-009 ready_o  output  1  means the block can accept a request this cycle.
REQ-010 rvalid_o  output  1  is the one-cycle completion strobe.
REQ-011 rdata_o  output  32  is the load data, valid only while rvalid_o=1.
REQ-012 err_o  output  1  is the access-fault flag, valid only while rvalid_o=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-014 ready_o SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted on a rising edge where req_i=1 and ready_o=1; we_i, addr_i and wdata_i SHALL be latched on that edge.
REQ-016 On acceptance, the FSM SHALL go to WAIT and load a 4-bit down-counter with WAIT_CYCLES-1 if WAIT_CYCLES>0; if WAIT_CYCLES=0 it SHALL go directly to RESP.
REQ-017 In WAIT, the counter SHALL decrement each cycle; when the counter equals 0, the next state SHALL be RESP.
REQ-018 rvalid_o SHALL be 1 for exactly one cycle, in RESP, WAIT_CYCLES+1 cycles after the accepting edge; RESP SHALL always return to IDLE.
REQ-019 req_i, we_i, addr_i and wdata_i SHALL be ignored outside IDLE; a held req_i SHALL be accepted again only on the next IDLE edge (back-to-back period = WAIT_CYCLES+2 cycles).
REQ-020 The word index SHALL be the latched addr[31:2].
REQ-021 A fault SHALL be flagged when latched addr[1:0]!=0 or the word index >= DEPTH.
REQ-022 On a fault: err_o=1 and rdata_o=0 in RESP, and memory SHALL be left unmodified.
REQ-023 A store without fault SHALL write the latched wdata to mem[index] on the edge entering RESP; rdata_o SHALL be 0 and err_o 0 in RESP.
REQ-024 A load without fault SHALL register mem[index] into rdata_o on the edge entering RESP; err_o SHALL be 0.
REQ-025 A load after a store to the same word SHALL return the stored value.
REQ-026 Outside RESP, rdata_o SHALL be 0 and err_o 0.
REQ-027 Address bits above the index range SHALL NOT alias: index >= DEPTH is a fault, never a wrap.

Reset
REQ-028 While rst_n=0, the following outputs SHALL hold: ready_o=0, rvalid_o=0, rdata_o=0 and err_o=0.
REQ-029 While rst_n=0, the FSM SHALL be in IDLE, the counter at 0, and all DEPTH memory words at 0.
REQ-030 After rst_n rises, ready_o SHALL be 1 from the first clock edge onward, because the FSM is in IDLE.
REQ-031 Reset asserted mid-access (in WAIT or RESP) SHALL abort the access immediately: no memory write, no rvalid_o pulse, and the FSM returns to IDLE.

Verification
REQ-032 Scenario: WAIT_CYCLES=2, store addr 0x10 data 0xDEADBEEF, then load 0x10 -> each rvalid_o pulses exactly 3 cycles after its accepting edge; load rdata_o=0xDEADBEEF, err_o=0.
REQ-033 Scenario: load 0x13 (misaligned) -> rvalid_o=1, err_o=1, rdata_o=0; a subsequent load 0x10 still returns its prior value.
REQ-034 Scenario: DEPTH=128, store 0x200 (index 128) -> err_o=1; a load of 0x0 returns 0, proving no wrap.
REQ-035 Scenario: req_i held high for 20 cycles with WAIT_CYCLES=2 -> exactly 5 accepts, 4 cycles apart; ready_o low between accepts.
REQ-036 Scenario: WAIT_CYCLES=0, store 0x4 data 0x1234 -> rvalid_o is high in the cycle after accept; load 0x4 returns 0x1234.
REQ-037 Scenario: reset asserted during WAIT of a store to 0x8 -> no rvalid_o pulse; after release, load 0x8 returns 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data memory slave with fault detection
module data_mem_responder #(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [29:0] idx;
  logic        fault;
  logic        enter_resp;
  logic        wr_en;

  // Next state, counter and request capture; only IDLE listens to the CPU
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (req_i) begin
        we_d    = we_i;
        addr_d  = addr_i;
        wdata_d = wdata_i;
        state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
        cnt_d   = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else cnt_d = cnt_q - 4'd1;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access resolution; with zero wait states RESP is entered straight from IDLE,
  // so the live inputs stand in for the not-yet-latched copies
  always_comb begin
    acc_we     = state_q == IDLE ? we_i : we_q;
    acc_addr   = state_q == IDLE ? addr_i : addr_q;
    acc_wdata  = state_q == IDLE ? wdata_i : wdata_q;
    idx        = acc_addr[31:2];
    fault      = (acc_addr[1:0] != 2'b00) || ({2'b00, idx} >= 32'(DEPTH));
    enter_resp = state_d == RESP;
    wr_en      = enter_resp && acc_we && !fault;
    rdata_d    = (enter_resp && !acc_we && !fault) ? mem_q[idx[AW-1:0]] : 32'd0;
    err_d      = enter_resp && fault;
  end

  // Control and response registers; reset aborts any access in flight
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array, cleared by reset and written on the edge entering RESP
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (wr_en) begin
      mem_q[idx[AW-1:0]] <= acc_wdata;
    end
  end

  assign ready_o  = rst_n && state_q == IDLE;
  assign rvalid_o = state_q == RESP;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: checks two responder instances (2 and 0 wait states) against a memory model
module tb_data_mem_responder;
  localparam int DEPTH = 128;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        ready_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic        ready0, rvalid0, err0;
  logic [31:0] rdata0;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] model [DEPTH];

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .ready_o(ready_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk_i), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .ready_o(ready0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
  endtask

  // One request pulse seen by both instances; records the first response of each
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd2, output logic [31:0] rd0,
                        output logic e2, output logic e0, output int l2, output int l0,
                        output int n2, output int n0, output int rb);
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
    @(posedge clk_i); #1;
    req_i = 1'b0; we_i = ~we; addr_i = ~a; wdata_i = ~d;
    l2 = -1; l0 = -1; n2 = 0; n0 = 0; rb = 0; rd2 = 32'd0; rd0 = 32'd0; e2 = 1'b0; e0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (rvalid_o) begin
        n2++;
        if (l2 < 0) begin l2 = k; rd2 = rdata_o; e2 = err_o; end
      end
      if (rvalid0) begin
        n0++;
        if (l0 < 0) begin l0 = k; rd0 = rdata0; e0 = err0; end
      end
      if (ready_o != (k >= 3)) rb++;
      if (ready0 != (k >= 1)) rb++;
      if (!rvalid_o && (rdata_o != 0 || err_o)) rb++;
      if (!rvalid0 && (rdata0 != 0 || err0)) rb++;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic run_vec(input string name, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd);
    logic [31:0] rd2, rd0;
    logic e2, e0;
    int l2, l0, n2, n0, rb;
    logic flt;
    access(we, a, d, rd2, rd0, e2, e0, l2, l0, n2, n0, rb);
    chk({name, " lat2"}, 32'(l2), 32'd2);
    chk({name, " lat0"}, 32'(l0), 32'd0);
    chk({name, " pulses"}, 32'(n2 * 16 + n0), 32'h11);
    chk({name, " err2"}, {31'd0, e2}, {31'd0, exp_err});
    chk({name, " err0"}, {31'd0, e0}, {31'd0, exp_err});
    chk({name, " rdata2"}, rd2, exp_rd);
    chk({name, " rdata0"}, rd0, exp_rd);
    chk({name, " idle_outputs"}, 32'(rb), 32'd0);
    flt = (a % 4 != 0) || (a / 4 >= DEPTH);
    if (we && !flt) model[a / 4] = d;
  endtask

  initial begin
    int acc2, acc0, last2, pulses;
    logic [31:0] a, d, exp_rd;
    logic we, flt;
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 32'h0000_0200, 32'h1111_2222, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_01FC, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_01FC, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[8]  = '{1'b0, 32'h0000_0200, 32'h0,         1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h8000_0010, 32'h0,         1'b1, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_0002, 32'h7777_7777, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_0004, 32'h0000_1234, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h0000_1234};
    clear_model();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst ready", {28'd0, ready_o, rvalid_o, err_o, ready0}, 32'd0);
    chk("rst rdata", rdata_o | rdata0, 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i); #1;
    chk("ready after reset", {30'd0, ready_o, ready0}, 32'd3);

    for (int i = 0; i < 13; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_err, vecs[i].exp_rdata);

    acc2 = 0; acc0 = 0; last2 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10;
      if (ready_o) begin
        acc2++;
        if (last2 >= 0) chk("hold gap", 32'(i - last2), 32'd4);
        last2 = i;
      end
      if (ready0) acc0++;
    end
    req_i = 1'b0;
    chk("hold accepts2", 32'(acc2), 32'd5);
    chk("hold accepts0", 32'(acc0), 32'd10);
    repeat (6) @(posedge clk_i);
    #1;

    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h8; wdata_i = 32'h5555_AAAA;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b0;
    #1;
    chk("midrst outs", {28'd0, ready_o, rvalid_o, err_o, rvalid0}, 32'd0);
    chk("midrst rdata", rdata_o, 32'd0);
    clear_model();
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      if (rvalid_o || !ready_o) pulses++;
    end
    chk("midrst no pulse", 32'(pulses), 32'd0);
    run_vec("after_rst ld8", 1'b0, 32'h8, 32'h0, 1'b0, 32'h0);
    run_vec("after_rst ld10", 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'($urandom_range(0, DEPTH + 3)) * 4;
        1: a = 32'($urandom_range(0, 7)) * 4;
        2: a = (32'($urandom_range(0, DEPTH - 1)) * 4) | 32'($urandom_range(1, 3));
        default: a = $urandom;
      endcase
      we = 1'($urandom_range(0, 1));
      d = $urandom;
      flt = (a % 4 != 0) || (a / 4 >= DEPTH);
      exp_rd = (!flt && !we) ? model[a / 4] : 32'd0;
      run_vec($sformatf("rnd%0d", i), we, a, d, flt, exp_rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
